// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU units: operation and FSM state
// encodings, plus the result-bit selector used by the compare operations.
package alu_pkg;

    localparam logic [1:0] OP_SLT  = 2'b00;
    localparam logic [1:0] OP_SLTU = 2'b01;
    localparam logic [1:0] OP_SEQ  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Single-bit compare result derived from the flags of A - B.
    function automatic logic cmp_bit(input logic [1:0] op, input logic n,
                                     input logic v, input logic c, input logic z);
        logic r;
        case (op)
            OP_SLT:  r = n ^ v;
            OP_SLTU: r = ~c;
            OP_SEQ:  r = z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/slt_serial_if.sv
// Start/busy/done request bus shared by the iterative ALU units.
interface slt_serial_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       opSel;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;
    logic             zeroFlag;
    logic             overflowFlag;
    logic             carryoutFlag;
    logic             negativeFlag;

    modport master (
        output start, opSel, busA, busB,
        input  busy, done, dataOut, zeroFlag, overflowFlag, carryoutFlag, negativeFlag
    );

    modport slave (
        input  start, opSel, busA, busB,
        output busy, done, dataOut, zeroFlag, overflowFlag, carryoutFlag, negativeFlag
    );

endinterface

// File: rtl/sub_digit.sv
// One DIGIT-wide ripple slice of A + ~B + cin. Also exposes the carry into
// the slice's top bit so the caller can form signed overflow on the last beat.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] c_s;

    // Ripple carry through the slice, bit by bit.
    always_comb begin
        c_s    = {(DIGIT+1){1'b0}};
        sum    = {DIGIT{1'b0}};
        c_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c_s[DIGIT];
    assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/slt_serial.sv
// Digit-serial A - B unit: SLT / SLTU / SEQ / SUB with Z, V, C, N flags.
// The difference is built LSB-first, DIGIT bits per beat, over WIDTH/DIGIT beats.
module slt_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    slt_serial_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("slt_serial: WIDTH must be a positive multiple of DIGIT");
    end

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zf_q, zf_d;
    logic             vf_q, vf_d;
    logic             cf_q, cf_d;
    logic             nf_q, nf_d;

    logic [DIGIT-1:0] sum_s;
    logic             cout_s;
    logic             cmsb_s;
    logic [WIDTH-1:0] sum_ext_s;
    logic             z_s;
    logic             v_s;
    logic             n_s;

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a    (opa_q[DIGIT-1:0]),
        .b    (opb_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (sum_s),
        .cout (cout_s),
        .cmsb (cmsb_s)
    );

    // Slice sum placed at the top of the word, ready to enter the diff register.
    assign sum_ext_s = WIDTH'(sum_s) << (WIDTH - DIGIT);

    // Next-state: accept in IDLE, one slice per beat in RUN, publish on the last beat.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        beat_d  = beat_q;
        diff_d  = diff_q;
        done_d  = 1'b0;
        data_d  = data_q;
        zf_d    = zf_q;
        vf_d    = vf_q;
        cf_d    = cf_q;
        nf_d    = nf_q;
        z_s     = 1'b0;
        v_s     = 1'b0;
        n_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.busA;
                    opb_d   = ~bus.busB;
                    op_d    = bus.opSel;
                    carry_d = 1'b1;
                    zacc_d  = 1'b1;
                    beat_d  = {BW{1'b0}};
                    diff_d  = {WIDTH{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                diff_d  = (diff_q >> DIGIT) | sum_ext_s;
                carry_d = cout_s;
                zacc_d  = zacc_q & (sum_s == {DIGIT{1'b0}});
                beat_d  = beat_q + BW'(1);
                if (beat_q == BW'(N - 1)) begin
                    // Final slice holds bit WIDTH-1: its carries give C and V.
                    z_s     = zacc_d;
                    v_s     = cmsb_s ^ cout_s;
                    n_s     = sum_s[DIGIT-1];
                    zf_d    = z_s;
                    vf_d    = v_s;
                    cf_d    = cout_s;
                    nf_d    = n_s;
                    beat_d  = {BW{1'b0}};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (op_q == OP_SUB) begin
                        data_d = diff_d;
                    end else begin
                        data_d = {{(WIDTH-1){1'b0}}, cmp_bit(op_q, n_s, v_s, cout_s, z_s)};
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset discards any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            op_q    <= 2'b00;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            beat_q  <= {BW{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            done_q  <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            zf_q    <= 1'b0;
            vf_q    <= 1'b0;
            cf_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            beat_q  <= beat_d;
            diff_q  <= diff_d;
            done_q  <= done_d;
            data_q  <= data_d;
            zf_q    <= zf_d;
            vf_q    <= vf_d;
            cf_q    <= cf_d;
            nf_q    <= nf_d;
        end
    end

    assign bus.busy         = (state_q == ST_RUN);
    assign bus.done         = done_q;
    assign bus.dataOut      = data_q;
    assign bus.zeroFlag     = zf_q;
    assign bus.overflowFlag = vf_q;
    assign bus.carryoutFlag = cf_q;
    assign bus.negativeFlag = nf_q;

endmodule

// File: tb/tb_slt_serial.sv
// Bench for slt_serial: a WIDTH=32/DIGIT=4 instance and a DIGIT=32 instance,
// checked every cycle against an arithmetic reference plus literal expectations.
module tb_slt_serial;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic chk_en;
    always #5 clk = ~clk;

    slt_serial_if #(.WIDTH(32)) if0 ();
    slt_serial_if #(.WIDTH(32)) if1 ();

    slt_serial #(.WIDTH(32), .DIGIT(4))  u_dut (.clk(clk), .reset(reset), .bus(if0));
    slt_serial #(.WIDTH(32), .DIGIT(32)) u_deg (.clk(clk), .reset(reset), .bus(if1));

    logic        st[2];
    logic [1:0]  sel[2];
    logic [31:0] ba[2];
    logic [31:0] bb[2];
    logic        o_busy[2];
    logic        o_done[2];
    logic [31:0] o_data[2];
    logic [3:0]  o_flags[2];   // {Z, V, C, N}

    assign if0.start = st[0];  assign if0.opSel = sel[0];
    assign if0.busA  = ba[0];  assign if0.busB  = bb[0];
    assign if1.start = st[1];  assign if1.opSel = sel[1];
    assign if1.busA  = ba[1];  assign if1.busB  = bb[1];
    assign o_busy[0]  = if0.busy;  assign o_done[0] = if0.done;  assign o_data[0] = if0.dataOut;
    assign o_busy[1]  = if1.busy;  assign o_done[1] = if1.done;  assign o_data[1] = if1.dataOut;
    assign o_flags[0] = {if0.zeroFlag, if0.overflowFlag, if0.carryoutFlag, if0.negativeFlag};
    assign o_flags[1] = {if1.zeroFlag, if1.overflowFlag, if1.carryoutFlag, if1.negativeFlag};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flg;
    } res_t;

    // Reference result straight from integer arithmetic on A and B.
    function automatic res_t ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [31:0] d;
        logic        z, v, c, n;
        d = a - b;
        z = (a == b);
        c = (a >= b);
        n = d[31];
        v = (a[31] != b[31]) && (d[31] != a[31]);
        case (op)
            OP_SLT:  r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r.data = (a < b) ? 32'd1 : 32'd0;
            OP_SEQ:  r.data = (a == b) ? 32'd1 : 32'd0;
            default: r.data = d;
        endcase
        r.flg = {z, v, c, n};
        return r;
    endfunction

    function automatic int nb(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    // Behavioural model: accept when idle, complete nb(k) edges later.
    bit          m_busy[2];
    bit          m_done[2];
    int          m_cnt[2];
    res_t        m_res[2];
    logic [1:0]  m_op[2];
    logic [31:0] m_a[2];
    logic [31:0] m_b[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_cnt[k]  <= 0;
                m_res[k]  <= '0;
            end else begin
                m_done[k] <= 1'b0;
                if (!m_busy[k]) begin
                    if (st[k]) begin
                        m_busy[k] <= 1'b1;
                        m_cnt[k]  <= nb(k);
                        m_op[k]   <= sel[k];
                        m_a[k]    <= ba[k];
                        m_b[k]    <= bb[k];
                    end
                end else if (m_cnt[k] == 1) begin
                    m_busy[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_res[k]  <= ref_op(m_op[k], m_a[k], m_b[k]);
                end else begin
                    m_cnt[k] <= m_cnt[k] - 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cyc_busy%0d", k), 64'(o_busy[k]), 64'(m_busy[k]));
                chk($sformatf("cyc_done%0d", k), 64'(o_done[k]), 64'(m_done[k]));
                chk($sformatf("cyc_data%0d", k), 64'(o_data[k]), 64'(m_res[k].data));
                chk($sformatf("cyc_flags%0d", k), 64'(o_flags[k]), 64'(m_res[k].flg));
            end
        end
    end

    // Issue one operation (called just after a negedge) and wait, bounded, for done.
    task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output res_t got, output int lat);
        bit ok;
        ok    = 1'b0;
        got   = '0;
        lat   = 0;
        st[k] = 1'b1; sel[k] = op; ba[k] = a; bb[k] = b;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            st[k] = 1'b0;
            if (o_done[k]) begin
                got = {o_data[k], o_flags[k]};
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic lit(input string nm, input int k, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ed, input logic [3:0] ef, input int el);
        res_t g;
        int   lat;
        run_op(k, op, a, b, g, lat);
        chk({nm, "_data"},  64'(g.data), 64'(ed));
        chk({nm, "_flags"}, 64'(g.flg),  64'(ef));
        chk({nm, "_lat"},   64'(lat - 1), 64'(el));
        @(negedge clk);
        chk({nm, "_done_clr"}, 64'(o_done[k]), 64'd0);
        chk({nm, "_busy_clr"}, 64'(o_busy[k]), 64'd0);
    endtask

    task automatic vec(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t g;
        res_t e;
        int   lat;
        e = ref_op(op, a, b);
        run_op(k, op, a, b, g, lat);
        chk($sformatf("vec%0d_res", k), 64'(g), 64'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   cnt;
        int   t1;
        int   t2;
        logic [31:0] keep;
        chk_en = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; sel[k] = 2'b00; ba[k] = 32'd0; bb[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",  64'(o_busy[k]),  64'd0);
            chk("rst_done",  64'(o_done[k]),  64'd0);
            chk("rst_data",  64'(o_data[k]),  64'd0);
            chk("rst_flags", 64'(o_flags[k]), 64'd0);
        end
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);

        // Hand-computed results, flags as {Z,V,C,N}.
        lit("slt_0_1",     0, OP_SLT,  32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0001, 8);
        lit("slt_m1_1",    0, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0011, 8);
        lit("sltu_m1_1",   0, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0011, 8);
        lit("slt_ovf",     0, OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0110, 8);
        lit("sub_5_7",     0, OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0001, 8);
        lit("seq_eq",      0, OP_SEQ,  32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 4'b1010, 8);
        lit("seq_ne",      0, OP_SEQ,  32'h1234_5678, 32'h1234_5679, 32'h0000_0000, 4'b0001, 8);
        lit("sub_posovf",  0, OP_SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0101, 8);
        lit("deg_sltu",    1, OP_SLTU, 32'h0000_0003, 32'h0000_0009, 32'h0000_0001, 4'b0001, 1);
        lit("deg_subovf",  1, OP_SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0101, 1);

        // Further operand patterns against the reference.
        vec(0, OP_SUB,  32'hDEAD_BEEF, 32'h1234_5678);
        vec(0, OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000);
        vec(0, OP_SLTU, 32'h0000_0000, 32'h0000_0000);
        vec(0, OP_SEQ,  32'h0000_0000, 32'h0000_0000);
        vec(1, OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF);
        vec(1, OP_SEQ,  32'hA5A5_A5A5, 32'hA5A5_A5A4);

        // Starts while busy are dropped: exactly one done.
        cnt  = 0;
        keep = 32'd0;
        st[0] = 1'b1; sel[0] = OP_SUB; ba[0] = 32'd100; bb[0] = 32'd1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_done[0]) begin
                cnt++;
                keep = o_data[0];
            end
            st[0] = (i == 2) || (i == 5);
            if (i == 2) begin sel[0] = OP_SUB; ba[0] = 32'd7; bb[0] = 32'd3; end
        end
        chk("busy_start_ignored_cnt", 64'(cnt), 64'd1);
        chk("busy_start_ignored_data", 64'(keep), 64'h63);

        // Start held high: one result every 9 cycles.
        cnt = 0; t1 = 0; t2 = 0;
        st[0] = 1'b1; sel[0] = OP_SUB; ba[0] = 32'd20; bb[0] = 32'd5;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            if (o_done[0]) begin
                cnt++;
                if (cnt == 1) t1 = i;
                if (cnt == 2) t2 = i;
            end
        end
        st[0] = 1'b0;
        chk("held_start_cnt", 64'(cnt), 64'd3);
        chk("held_start_ii",  64'(t2 - t1), 64'd9);
        repeat (12) @(negedge clk);

        // Reset mid-operation at beat 4: cleared outputs, no done afterwards.
        st[0] = 1'b1; sel[0] = OP_SUB; ba[0] = 32'd9; bb[0] = 32'd2;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy",  64'(o_busy[0]),  64'd0);
        chk("abort_done",  64'(o_done[0]),  64'd0);
        chk("abort_data",  64'(o_data[0]),  64'd0);
        chk("abort_flags", 64'(o_flags[0]), 64'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_done[0]) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);

        lit("post_abort", 0, OP_SLTU, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 4'b0001, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
